apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB3 master that turns simple valid/ready register commands into single APB transfers.
- Sits directly upstream of the APB-SPI top level and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA inputs.
- Returns PRDATA/PSLVERR, plus a timeout flag, on a response channel.
- Lets firmware-side logic or a sequencer program CR1/CR2/BR/DR without hand-timed APB phases.

Parameters:
- ADDR_W, 3, APB address width (matches the SPI register map).
- DATA_W, 8, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET_n  input  1  synchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  master can accept a command.
- cmd_write_i  input  1  1=write, 0=read.
- cmd_addr_i  input  ADDR_W  target register address.
- cmd_wdata_i  input  DATA_W  write data.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  response consumed.
- rsp_rdata_o  output  DATA_W  read data (0 for writes).
- rsp_err_o  output  1  PSLVERR seen or timeout.
- rsp_timeout_o  output  1  transfer aborted by timeout.
- busy_o  output  1  transfer in progress (any state but IDLE).
- PSEL_o  output  1  APB select.
- PENABLE_o  output  1  APB enable.
- PWRITE_o  output  1  APB direction.
- PADDR_o  output  ADDR_W  APB address.
- PWDATA_o  output  DATA_W  APB write data.
- PREADY_i  input  1  slave ready.
- PRDATA_i  input  DATA_W  slave read data.
- PSLVERR_i  input  1  slave error.

Behaviour:
- Reset (PRESET_n low at a rising PCLK): state=IDLE, all outputs 0, wait counter 0. Reset mid-transfer aborts immediately; PSEL/PENABLE are 0 the next cycle and no response is issued.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE: cmd_ready_o=1, PSEL_o=0, PENABLE_o=0. On cmd_valid_i&cmd_ready_o:
  - latch write/addr/wdata into PWRITE_o/PADDR_o/PWDATA_o;
  - go to SETUP.
- SETUP (exactly 1 cycle): PSEL_o=1, PENABLE_o=0; go to ACCESS.
- ACCESS: PSEL_o=1, PENABLE_o=1; PADDR/PWRITE/PWDATA held stable.
  - If PREADY_i=1: rsp_rdata_o = PRDATA_i for reads, 0 for writes; rsp_err_o = PSLVERR_i; rsp_timeout_o = 0; go to RESP.
  - Else wait counter +1. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with PREADY_i still 0: rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; go to RESP.
  - PREADY_i on the same cycle as the timeout limit counts as a completion, not a timeout.
- RESP: PSEL_o=0, PENABLE_o=0, rsp_valid_o=1; response fields held stable. When rsp_ready_i=1: clear rsp_valid_o, clear the counter, go to IDLE.
- Latency: command accepted at edge N gives SETUP in cycle N+1, ACCESS in N+2, and rsp_valid_o in N+3 for a zero-wait slave. Back-to-back commands start 1 cycle after the response handshake (cmd_ready_o only in IDLE), i.e. a minimum of 4 cycles per transfer when rsp_ready_i is held high.
- PADDR_o/PWDATA_o/PWRITE_o keep their last values outside transfers; they change only on command accept.
- cmd_* inputs are ignored outside IDLE. rsp_ready_i is ignored outside RESP.
- Wait counter width is clog2(TIMEOUT+1), minimum 1 bit; it never wraps, because the transition to RESP occurs first.

Test Plan:
- Write 0xF5 to addr 0 with zero-wait slave (PREADY tied 1) → PSEL rises 1 cycle after accept, PENABLE 1 cycle later, single ACCESS cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Program sequence CR1=0xF5 @0, CR2=0xC4 @1, BR=0x01 @2, DR=0xAA @5 into the SPI top level with rsp_ready held 1 → readback of addr 0/1/2 returns 0xF5/0xC4/0x01; SPI ss_o goes low after DR write.
- Read with slave inserting 3 wait states (PREADY low 3 ACCESS cycles) → PENABLE high 4 cycles, PADDR stable throughout, rsp_rdata = PRDATA value at PREADY cycle (e.g. 0x5A).
- Slave never asserts PREADY, TIMEOUT=16 → exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PSLVERR=1 with PREADY on a write to addr 7 → rsp_err=1, rsp_timeout=0. Hold rsp_ready=0 for 5 cycles → rsp_valid and fields held, cmd_ready stays 0.
- Assert PRESET_n low during ACCESS → next cycle PSEL=PENABLE=0, rsp_valid=0, cmd_ready=0 while in reset, cmd_ready=1 the cycle after release. A new command then completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB3 master: converts a valid/ready register command into one APB transfer
// and returns read data, slave error and timeout status on a response channel.
module apb_cmd_master #(
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET_n,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_timeout_o,
   output logic              busy_o,
   output logic              PSEL_o,
   output logic              PENABLE_o,
   output logic              PWRITE_o,
   output logic [ADDR_W-1:0] PADDR_o,
   output logic [DATA_W-1:0] PWDATA_o,
   input  logic              PREADY_i,
   input  logic [DATA_W-1:0] PRDATA_i,
   input  logic              PSLVERR_i
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              busy_q, busy_d;

   // Next state plus next values of every output flop; strobes follow state_d
   // so each output is a flop with no input-to-output combinational path.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               pwrite_d = cmd_write_i;
               paddr_d  = cmd_addr_i;
               pwdata_d = cmd_wdata_i;
               cnt_d    = '0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (PREADY_i) begin
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA_i;
               rsp_err_d     = PSLVERR_i;
               rsp_timeout_d = 1'b0;
               state_d       = S_RESP;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_d   = (state_d == S_ACCESS);
      rsp_valid_d = (state_d == S_RESP);
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cmd_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cmd_ready_q   <= cmd_ready_d;
         busy_q        <= busy_d;
      end
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;
   assign busy_o        = busy_q;
   assign PSEL_o        = psel_q;
   assign PENABLE_o     = penable_q;
   assign PWRITE_o      = pwrite_q;
   assign PADDR_o       = paddr_q;
   assign PWDATA_o      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural register-file slave with programmable
// wait states/errors, and a transaction-level reference model of responses.
module tb_apb_cmd_master;

   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam int          NEVER   = 255;

   logic              PCLK = 1'b0;
   logic              PRESET_n;
   logic              cmd_valid_i, cmd_write_i;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [DATA_W-1:0] cmd_wdata_i;
   logic              cmd_ready_o;
   logic              rsp_valid_o, rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o, rsp_timeout_o, busy_o;
   logic              PSEL_o, PENABLE_o, PWRITE_o;
   logic [ADDR_W-1:0] PADDR_o;
   logic [DATA_W-1:0] PWDATA_o;
   logic              PREADY_i, PSLVERR_i;
   logic [DATA_W-1:0] PRDATA_i;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
      .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o),
      .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
      .PREADY_i(PREADY_i), .PRDATA_i(PRDATA_i), .PSLVERR_i(PSLVERR_i)
   );

   // Slave: register file that answers after slv_wait not-ready ACCESS cycles
   logic [DATA_W-1:0] slv_mem [8];
   logic [DATA_W-1:0] ref_mem [8];
   int slv_wait = 0;
   bit slv_err  = 1'b0;
   int acc_cnt  = 0;

   always @(negedge PCLK) begin
      if (PSEL_o && PENABLE_o) begin
         if (acc_cnt >= slv_wait) begin
            PREADY_i  = 1'b1;
            PSLVERR_i = slv_err;
            PRDATA_i  = PWRITE_o ? DATA_W'($urandom) : slv_mem[PADDR_o];
            if (PWRITE_o && !slv_err) slv_mem[PADDR_o] = PWDATA_o;
         end else begin
            PREADY_i  = 1'b0;
            PSLVERR_i = 1'($urandom);
            PRDATA_i  = DATA_W'($urandom);
         end
         acc_cnt++;
      end else begin
         acc_cnt   = 0;
         PREADY_i  = 1'($urandom);
         PSLVERR_i = 1'($urandom);
         PRDATA_i  = DATA_W'($urandom);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One command through to the response handshake; hold = cycles rsp_ready stays low
   task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits,
                         input bit err, input int hold);
      int acc_exp, acc_seen, k;
      bit to_exp, err_exp, got, stable_bad, held_bad;
      logic [DATA_W-1:0] rd_exp;
      to_exp  = (waits >= int'(TIMEOUT));
      acc_exp = to_exp ? int'(TIMEOUT) : waits + 1;
      err_exp = to_exp || err;
      rd_exp  = (wr || to_exp) ? '0 : ref_mem[addr];
      if (wr && !to_exp && !err) ref_mem[addr] = wdata;
      slv_wait = waits;
      slv_err  = err;

      @(negedge PCLK);
      cmd_valid_i = 1'b1;
      cmd_write_i = wr;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      rsp_ready_i = (hold == 0);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready_o) begin got = 1'b1; break; end
         @(negedge PCLK);
      end
      check_eq("cmd_accept", 32'(got), 32'd1);
      if (!got) begin cmd_valid_i = 1'b0; return; end

      k = 0; acc_seen = 0; got = 1'b0; stable_bad = 1'b0;
      while (k < 200) begin
         @(negedge PCLK);
         k++;
         if (k == 1) begin
            cmd_valid_i = 1'b0;
            cmd_write_i = 1'($urandom);
            cmd_addr_i  = ADDR_W'($urandom);
            cmd_wdata_i = DATA_W'($urandom);
            check_eq("setup_phase", {30'd0, PSEL_o, PENABLE_o}, 32'd2);
         end
         if (PSEL_o && PENABLE_o) acc_seen++;
         if (PADDR_o !== addr || PWRITE_o !== wr || (wr && PWDATA_o !== wdata)) stable_bad = 1'b1;
         if (rsp_valid_o) begin got = 1'b1; break; end
      end
      check_eq("rsp_seen", 32'(got), 32'd1);
      check_eq("rsp_latency", 32'(k), 32'(acc_exp + 2));
      check_eq("access_cycles", 32'(acc_seen), 32'(acc_exp));
      check_eq("apb_stable", 32'(stable_bad), 32'd0);
      check_eq("rsp_rdata", 32'(rsp_rdata_o), 32'(rd_exp));
      check_eq("rsp_err", 32'(rsp_err_o), 32'(err_exp));
      check_eq("rsp_timeout", 32'(rsp_timeout_o), 32'(to_exp));
      check_eq("resp_bus", {28'd0, PSEL_o, PENABLE_o, cmd_ready_o, busy_o}, 32'd1);

      held_bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge PCLK);
         if (!rsp_valid_o || rsp_rdata_o !== rd_exp || rsp_err_o !== err_exp ||
             rsp_timeout_o !== to_exp || cmd_ready_o) held_bad = 1'b1;
      end
      if (hold > 0) check_eq("rsp_held", 32'(held_bad), 32'd0);
      rsp_ready_i = 1'b1;
      @(negedge PCLK);
      rsp_ready_i = 1'b0;
      check_eq("back_idle", {29'd0, rsp_valid_o, cmd_ready_o, busy_o}, 32'd2);
   endtask

   initial begin
      logic [DATA_W-1:0] v;
      PRESET_n    = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_wdata_i = '0;
      rsp_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = DATA_W'($urandom);
         slv_mem[i] = v;
         ref_mem[i] = v;
      end
      repeat (3) @(negedge PCLK);
      check_eq("reset_ctrl", {25'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                              busy_o, PSEL_o, PENABLE_o}, 32'd0);
      check_eq("reset_data", {16'd0, rsp_rdata_o, PWDATA_o}, 32'd0);
      check_eq("reset_addr", {28'd0, PWRITE_o, PADDR_o}, 32'd0);
      PRESET_n = 1'b1;
      @(negedge PCLK);
      check_eq("ready_after_reset", 32'(cmd_ready_o), 32'd1);

      // Register programming and readback, zero-wait slave, rsp_ready held high
      do_txn(1'b1, 3'd0, 8'hF5, 0, 1'b0, 0);
      do_txn(1'b1, 3'd1, 8'hC4, 0, 1'b0, 0);
      do_txn(1'b1, 3'd2, 8'h01, 0, 1'b0, 0);
      do_txn(1'b1, 3'd5, 8'hAA, 0, 1'b0, 0);
      do_txn(1'b0, 3'd0, 8'h00, 0, 1'b0, 0);
      check_eq("readback_cr1", 32'(rsp_rdata_o), 32'hF5);
      do_txn(1'b0, 3'd1, 8'h00, 0, 1'b0, 0);
      check_eq("readback_cr2", 32'(rsp_rdata_o), 32'hC4);
      do_txn(1'b0, 3'd2, 8'h00, 0, 1'b0, 0);
      check_eq("readback_br", 32'(rsp_rdata_o), 32'h01);

      // Wait states, timeout boundary and slave error with stalled response
      do_txn(1'b1, 3'd3, 8'h5A, 0, 1'b0, 0);
      do_txn(1'b0, 3'd3, 8'h00, 3, 1'b0, 0);
      check_eq("wait3_rdata", 32'(rsp_rdata_o), 32'h5A);
      do_txn(1'b0, 3'd4, 8'h00, NEVER, 1'b0, 0);
      do_txn(1'b0, 3'd1, 8'h00, int'(TIMEOUT) - 1, 1'b0, 1);
      do_txn(1'b1, 3'd6, 8'h33, int'(TIMEOUT), 1'b0, 2);
      do_txn(1'b1, 3'd7, 8'h99, 0, 1'b1, 5);

      // Reset while in ACCESS aborts without a response
      slv_wait = 10;
      @(negedge PCLK);
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 3'd2;
      @(negedge PCLK);
      cmd_valid_i = 1'b0;
      repeat (3) @(negedge PCLK);
      check_eq("pre_reset_access", {30'd0, PSEL_o, PENABLE_o}, 32'd3);
      PRESET_n = 1'b0;
      @(negedge PCLK);
      check_eq("mid_reset_abort", {28'd0, PSEL_o, PENABLE_o, rsp_valid_o, cmd_ready_o}, 32'd0);
      @(negedge PCLK);
      check_eq("in_reset_ready", {30'd0, cmd_ready_o, busy_o}, 32'd0);
      PRESET_n = 1'b1;
      @(negedge PCLK);
      check_eq("release_ready", {30'd0, cmd_ready_o, rsp_valid_o}, 32'd2);
      do_txn(1'b0, 3'd2, 8'h00, 1, 1'b0, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         int w;
         case ($urandom_range(0, 5))
            0, 1: w = 0;
            2:    w = int'($urandom_range(1, 4));
            3:    w = int'(TIMEOUT) - 1;
            4:    w = int'(TIMEOUT);
            default: w = NEVER;
         endcase
         do_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), w,
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1, "watchdog");
   end

endmodule
